morse_digit_player: RTL and testbench
=====================================

Name: morse_digit_player

Overview:
- Sequencer that plays one decimal digit (0-9) as timed International Morse code on a single LED output.
- Sits between the board switches and LEDs, alongside the combinational digit-to-Morse display logic.
- Captures a 4-bit digit when the operator raises `start`, then drives `led` through 5 marks and the required spacing.
- Contains its own digit-to-pattern decoder; pulses `done` when the digit has finished playing.

Parameters:
- UNIT_CYCLES, default 12500000, clock cycles per Morse time unit (0.25 s at 50 MHz); legal range >= 2.
- CNT_W, default 24, width of the unit cycle counter; must satisfy 2^CNT_W > UNIT_CYCLES.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- digit, input, 4, BCD digit to play, unsigned; values 10-15 are invalid.
- start, input, 1, level from a switch; asynchronous to clock.
- abort, input, 1, synchronous; stops playback immediately.
- led, output, 1, Morse output (1 = mark).
- busy, output, 1, high from capture until the end of the final gap.
- done, output, 1, one-cycle pulse when playback completes normally.
- error, output, 1, sticky flag set by an invalid digit on `start`.
- is_dash, output, 1, kind of the current/last mark (1 = dash).

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, synchronizer and edge flops 0, counters 0.
- Start input path:
  - `start` goes through a 2-flop synchronizer, then an edge-detect flop.
  - start_evt = sync2 & ~sync3.
  - If start is high at rising edge k, start_evt is high during cycle k+1..k+2.
  - The FSM acts on edge k+2, so led=1 is visible after edge k+2.
- Pattern decode, p[4] = first symbol, 1 = dash:
  - 0 -> 11111
  - n in 1..5 -> first n symbols dot, rest dash
  - n in 6..9 -> first n-5 symbols dash, rest dot
- States: IDLE, MARK, SPACE, GAP. Unit counter counts 0..UNIT_CYCLES-1; one unit elapses when counter = UNIT_CYCLES-1.
- IDLE:
  - busy=0, led=0.
  - start_evt with digit<=9: latch pattern, sym=0, error<=0, goto MARK with len = p[4] ? 3 : 1 units.
  - start_evt with digit>9: error<=1, stay IDLE.
- MARK:
  - led=1, busy=1, is_dash=current symbol.
  - After len units: if sym==4 goto GAP (3 units), else goto SPACE (1 unit).
- SPACE:
  - led=0.
  - After 1 unit: sym<=sym+1, goto MARK with len from p[4-sym-1].
- GAP:
  - led=0, busy=1.
  - After 3 units: goto IDLE, done=1 for exactly that one cycle.
- led, busy, is_dash are registered outputs.
- Exact durations:
  - MARK = len*UNIT_CYCLES cycles; SPACE = UNIT_CYCLES cycles; GAP = 3*UNIT_CYCLES cycles.
  - Total busy cycles = (sum of mark units + 4 + 3) * UNIT_CYCLES.
- start_evt while busy is ignored; the digit is not re-sampled and error is not changed.
- abort=1 in any state:
  - Next edge: IDLE, led=0, busy=0, done=0, counters cleared, error unchanged.
  - abort has priority over start_evt in the same cycle.
- digit changing during playback has no effect; the pattern is latched at capture.
- Holding start high causes no replay; a new low->high transition is required.
- Reset asserted mid-playback: outputs 0 immediately, without waiting for a clock edge.

Test Plan:
- UNIT_CYCLES=4, digit=5, start raised -> led=1 after 3rd edge; 5 marks of 4 cycles separated by 4-cycle spaces; busy for 48 cycles; one done pulse; is_dash stays 0.
- UNIT_CYCLES=4, digit=0 -> five 12-cycle marks with is_dash=1; busy for 88 cycles; done pulses once at the end.
- digit=7 (pattern 11000) -> mark lengths 12,12,4,4,4 cycles; then digit=12 with a new start edge -> error=1, busy stays 0, led stays 0; then digit=3 with start -> error cleared at capture.
- abort during the 2nd mark of digit 2 -> led=0 and busy=0 on the next edge, no done pulse; a new start edge replays the digit from the first symbol.
- start toggled low->high during busy, and start held high after done -> no restart, no error change.
- reset pulsed low mid-SPACE without a clock edge -> all outputs 0 immediately; after release, normal operation on the next start edge.

Source files
------------

// File: rtl/morse_digit_player.sv
// Plays one captured decimal digit as International Morse code on a single LED.
// The switch-driven start input is synchronised and edge-detected; abort and reset stop playback at once.
module morse_digit_player #(
  parameter int UNIT_CYCLES = 12500000,
  parameter int CNT_W       = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       abort,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       is_dash
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       units_q;
  logic [2:0]       sym_q;
  logic [4:0]       pat_q;
  logic [2:0]       sync_q;

  logic       start_evt;
  logic       unit_done;
  logic       last_unit;
  logic       nxt_dash;
  logic [4:0] dec_p;

  // Bit 4 is the first symbol sent; 1 means dash.
  function automatic logic [4:0] decode(input logic [3:0] d);
    logic [4:0] p;
    p = '0;
    if (d == 4'd0) begin
      p = 5'b11111;
    end else if (d <= 4'd5) begin
      for (int j = 0; j < 5; j++) p[4-j] = (j >= int'(d));
    end else begin
      for (int j = 0; j < 5; j++) p[4-j] = (j < int'(d) - 5);
    end
    return p;
  endfunction

  assign dec_p     = decode(digit);
  assign start_evt = sync_q[1] & ~sync_q[2];
  assign unit_done = (cnt_q == CNT_W'(UNIT_CYCLES - 1));
  assign last_unit = unit_done && (units_q == 2'd1);
  assign nxt_dash  = pat_q[3'd3 - sym_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      units_q <= '0;
      sym_q   <= '0;
      pat_q   <= '0;
      sync_q  <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      is_dash <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], start};
      done   <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        units_q <= '0;
        sym_q   <= '0;
        led     <= 1'b0;
        busy    <= 1'b0;
      end else begin
        // Shared unit timer for all playing states; transitions below override units_q.
        if (state_q != IDLE) begin
          cnt_q <= unit_done ? '0 : cnt_q + CNT_W'(1);
          if (unit_done) units_q <= units_q - 2'd1;
        end
        case (state_q)
          IDLE: begin
            if (start_evt) begin
              if (digit <= 4'd9) begin
                pat_q   <= dec_p;
                sym_q   <= '0;
                error   <= 1'b0;
                state_q <= MARK;
                cnt_q   <= '0;
                units_q <= dec_p[4] ? 2'd3 : 2'd1;
                led     <= 1'b1;
                busy    <= 1'b1;
                is_dash <= dec_p[4];
              end else begin
                error <= 1'b1;
              end
            end
          end
          MARK: begin
            if (last_unit) begin
              led <= 1'b0;
              if (sym_q == 3'd4) begin
                state_q <= GAP;
                units_q <= 2'd3;
              end else begin
                state_q <= SPACE;
                units_q <= 2'd1;
              end
            end
          end
          SPACE: begin
            if (last_unit) begin
              sym_q   <= sym_q + 3'd1;
              state_q <= MARK;
              units_q <= nxt_dash ? 2'd3 : 2'd1;
              led     <= 1'b1;
              is_dash <= nxt_dash;
            end
          end
          GAP: begin
            if (last_unit) begin
              state_q <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_digit_player.sv
// Directed bench for morse_digit_player with a 4-cycle Morse unit.
module tb_morse_digit_player;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       led, busy, done, error, is_dash;

  int errs = 0;
  int checks = 0;

  int m_first, m_n, m_busy, m_done, m_gap, m_to;
  int m_len [8];
  int m_dash[8];
  int m_sp  [8];

  morse_digit_player #(.UNIT_CYCLES(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .digit(digit), .start(start), .abort(abort),
    .led(led), .busy(busy), .done(done), .error(error), .is_dash(is_dash)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Lower start, then raise it with a new digit (sampled at the following edge).
  task automatic new_start(input logic [3:0] d);
    start = 1'b0;
    repeat (3) step();
    digit = d;
    start = 1'b1;
  endtask

  // Records mark/space lengths and busy/done counts until busy falls.
  task automatic measure();
    int cur_on, cur_off, seen, ended;
    m_first = 0; m_n = 0; m_busy = 0; m_done = 0; m_gap = 0; m_to = 0;
    cur_on = 0; cur_off = 0; seen = 0; ended = 0;
    for (int k = 0; k < 8; k++) begin m_len[k] = 0; m_dash[k] = 0; m_sp[k] = 0; end
    for (int i = 1; i <= 400; i++) begin
      step();
      if (done) m_done++;
      if (busy) begin seen = 1; m_busy++; end
      if (led) begin
        if (m_first == 0) m_first = i;
        if (cur_on == 0 && m_n > 0 && m_n < 8) m_sp[m_n-1] = cur_off;
        cur_on++;
        cur_off = 0;
        if (m_n < 8) m_dash[m_n] = int'(is_dash);
      end else begin
        if (cur_on > 0) begin
          if (m_n < 8) m_len[m_n] = cur_on;
          m_n++;
          cur_on = 0;
        end
        if (busy && m_n > 0) cur_off++;
      end
      if (seen && !busy) begin m_gap = cur_off; ended = 1; break; end
    end
    m_to = !ended;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({led, busy, done, error, is_dash} !== 5'b0) begin
      errs++; $display("FAIL reset_outputs: got %b want 00000", {led, busy, done, error, is_dash});
    end
    #10 reset = 1'b1;
    step();
  endtask

  task automatic test_digit5();
    new_start(4'd5);
    step();
    checks++;
    if (led !== 1'b0) begin errs++; $display("FAIL d5_led_edge1: got %b want 0", led); end
    step();
    checks++;
    if (led !== 1'b0) begin errs++; $display("FAIL d5_led_edge2: got %b want 0", led); end
    step();
    checks++;
    if (led !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL d5_led_edge3: got led=%b busy=%b want 1 1", led, busy);
    end
    measure();
    checks++;
    if (m_to != 0) begin errs++; $display("FAIL d5_timeout: got %0d want 0", m_to); end
    // measure began after capture: first mark already showed one sample
    checks++;
    if (m_n != 5) begin errs++; $display("FAIL d5_marks: got %0d want 5", m_n); end
    checks++;
    if (m_len[0] != 3 || m_len[1] != 4 || m_len[4] != 4) begin
      errs++; $display("FAIL d5_len: got %0d %0d %0d want 3 4 4", m_len[0], m_len[1], m_len[4]);
    end
    checks++;
    if (m_sp[0] != 4 || m_sp[3] != 4) begin
      errs++; $display("FAIL d5_space: got %0d %0d want 4 4", m_sp[0], m_sp[3]);
    end
    checks++;
    if (m_gap != 12) begin errs++; $display("FAIL d5_gap: got %0d want 12", m_gap); end
    checks++;
    if (m_busy != 47) begin errs++; $display("FAIL d5_busy: got %0d want 47", m_busy); end
    checks++;
    if (m_done != 1) begin errs++; $display("FAIL d5_done: got %0d want 1", m_done); end
    checks++;
    if (m_dash[0] + m_dash[1] + m_dash[2] + m_dash[3] + m_dash[4] != 0) begin
      errs++; $display("FAIL d5_dash: got %0d want 0", m_dash[0] + m_dash[1] + m_dash[2] + m_dash[3] + m_dash[4]);
    end
    step();
    checks++;
    if (done !== 1'b0) begin errs++; $display("FAIL d5_done_width: got %b want 0", done); end
  endtask

  task automatic test_digit0();
    new_start(4'd0);
    measure();
    checks++;
    if (m_to != 0 || m_n != 5) begin errs++; $display("FAIL d0_marks: got %0d (to=%0d) want 5", m_n, m_to); end
    checks++;
    if (m_first != 3) begin errs++; $display("FAIL d0_first: got %0d want 3", m_first); end
    checks++;
    if (m_len[0] != 12 || m_len[2] != 12 || m_len[4] != 12) begin
      errs++; $display("FAIL d0_len: got %0d %0d %0d want 12", m_len[0], m_len[2], m_len[4]);
    end
    checks++;
    if (m_dash[0] + m_dash[1] + m_dash[2] + m_dash[3] + m_dash[4] != 5) begin
      errs++; $display("FAIL d0_dash: got %0d want 5", m_dash[0] + m_dash[1] + m_dash[2] + m_dash[3] + m_dash[4]);
    end
    checks++;
    if (m_busy != 88) begin errs++; $display("FAIL d0_busy: got %0d want 88", m_busy); end
    checks++;
    if (m_done != 1) begin errs++; $display("FAIL d0_done: got %0d want 1", m_done); end
  endtask

  task automatic test_digit7_error();
    new_start(4'd7);
    measure();
    checks++;
    if (m_to != 0 || m_n != 5) begin errs++; $display("FAIL d7_marks: got %0d (to=%0d) want 5", m_n, m_to); end
    checks++;
    if (m_len[0] != 12 || m_len[1] != 12 || m_len[2] != 4 || m_len[3] != 4 || m_len[4] != 4) begin
      errs++; $display("FAIL d7_len: got %0d %0d %0d %0d %0d want 12 12 4 4 4",
                       m_len[0], m_len[1], m_len[2], m_len[3], m_len[4]);
    end
    checks++;
    if (m_dash[0] != 1 || m_dash[1] != 1 || m_dash[2] != 0) begin
      errs++; $display("FAIL d7_dash: got %0d%0d%0d want 110", m_dash[0], m_dash[1], m_dash[2]);
    end
    checks++;
    if (m_busy != 64) begin errs++; $display("FAIL d7_busy: got %0d want 64", m_busy); end
    new_start(4'd12);
    repeat (6) step();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || led !== 1'b0) begin
      errs++; $display("FAIL d12_error: got err=%b busy=%b led=%b want 1 0 0", error, busy, led);
    end
    new_start(4'd3);
    measure();
    checks++;
    if (error !== 1'b0) begin errs++; $display("FAIL d3_error_clear: got %b want 0", error); end
    checks++;
    if (m_len[0] != 4 || m_len[2] != 4 || m_len[3] != 12 || m_len[4] != 12 || m_busy != 64) begin
      errs++; $display("FAIL d3_play: got %0d %0d %0d %0d busy=%0d want 4 4 12 12 busy=64",
                       m_len[0], m_len[2], m_len[3], m_len[4], m_busy);
    end
  endtask

  task automatic test_abort();
    int rises, prev, dcnt;
    new_start(4'd2);
    rises = 0; prev = 0;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      step();
      if (led && !prev) rises++;
      prev = int'(led);
    end
    checks++;
    if (rises != 2) begin errs++; $display("FAIL abort_reach_mark2: got %0d want 2", rises); end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (led !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL abort_stop: got led=%b busy=%b done=%b want 0 0 0", led, busy, done);
    end
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin step(); if (done || busy) dcnt++; end
    checks++;
    if (dcnt != 0) begin errs++; $display("FAIL abort_quiet: got %0d want 0", dcnt); end
    new_start(4'd2);
    measure();
    checks++;
    if (m_n != 5 || m_first != 3 || m_len[0] != 4 || m_len[2] != 12 || m_dash[2] != 1) begin
      errs++; $display("FAIL abort_replay: got n=%0d first=%0d l0=%0d l2=%0d d2=%0d want 5 3 4 12 1",
                       m_n, m_first, m_len[0], m_len[2], m_dash[2]);
    end
  endtask

  task automatic test_back_to_back();
    int bcnt, dcnt, ended;
    new_start(4'd5);
    bcnt = 0; dcnt = 0; ended = 0;
    for (int i = 0; i < 10; i++) begin step(); if (busy) bcnt++; if (done) dcnt++; end
    start = 1'b0;
    digit = 4'd12;
    for (int i = 0; i < 3; i++) begin step(); if (busy) bcnt++; if (done) dcnt++; end
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy) bcnt++;
      if (done) dcnt++;
      if (!busy) begin ended = 1; break; end
    end
    checks++;
    if (ended != 1 || bcnt != 48) begin errs++; $display("FAIL b2b_busy: got %0d want 48", bcnt); end
    checks++;
    if (dcnt != 1 || error !== 1'b0) begin
      errs++; $display("FAIL b2b_done_err: got done=%0d err=%b want 1 0", dcnt, error);
    end
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (busy || led || done || error) bcnt++; end
    checks++;
    if (bcnt != 0) begin errs++; $display("FAIL hold_no_replay: got %0d want 0", bcnt); end
  endtask

  task automatic test_async_reset();
    new_start(4'd0);
    repeat (16) step();
    checks++;
    if (led !== 1'b0 || busy !== 1'b1 || is_dash !== 1'b1) begin
      errs++; $display("FAIL rst_pre_space: got led=%b busy=%b dash=%b want 0 1 1", led, busy, is_dash);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({led, busy, done, error, is_dash} !== 5'b0) begin
      errs++; $display("FAIL rst_async: got %b want 00000", {led, busy, done, error, is_dash});
    end
    start = 1'b0;
    #3 reset = 1'b1;
    step();
    new_start(4'd0);
    measure();
    checks++;
    if (m_n != 5 || m_busy != 88 || m_done != 1) begin
      errs++; $display("FAIL rst_replay: got n=%0d busy=%0d done=%0d want 5 88 1", m_n, m_busy, m_done);
    end
  endtask

  initial begin
    test_reset();
    test_digit5();
    test_digit0();
    test_digit7_error();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
